mc_controller: RTL and testbench

//  Multicycle control FSM for the 16-bit IITB-RISC datapath. Sequences fetch, PC update and per-opcode

---
 rtl/mc_ctrl_pkg.sv | 43 ++++
 rtl/mc_ctrl_decode.sv | 83 ++++++++
 rtl/mc_controller.sv | 91 +++++++++
 tb/tb_mc_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath-select encodings for the IITB-RISC multicycle controller
package mc_ctrl_pkg;
  localparam int CNT_W = 3;
  localparam int ST_W = 5;
  typedef enum logic [ST_W-1:0] {
    S_IF0, S_IF1, S_IF2, S_IF3, S_EX, S_WB, S_MEM, S_BR0,
    S_BR1, S_J0, S_J1, S_J2, S_J3, S_MA, S_MX, S_MW
  } state_t;
  localparam logic [3:0] OP_ADD = 4'h0, OP_ADI = 4'h1, OP_NDU = 4'h2, OP_LHI = 4'h3;
  localparam logic [3:0] OP_LW = 4'h4, OP_SW = 4'h5, OP_LM = 4'h6, OP_SM = 4'h7;
  localparam logic [3:0] OP_JAL = 4'h8, OP_JLR = 4'h9, OP_BEQ = 4'hC;
  localparam logic [2:0] B_ZERO = 3'd0, B_ONE = 3'd1, B_RB = 3'd2, B_IMM6 = 3'd3, B_CNT = 3'd4;
  localparam logic [2:0] A_ZERO = 3'd0, A_ONE = 3'd1, A_SHL7 = 3'd2, A_IMM6 = 3'd3;
  localparam logic [2:0] A_IMM9 = 3'd4, A_RA = 3'd5, A_TMPA = 3'd6;
  localparam logic [1:0] WEN_OFF = 2'd0, WEN_ON = 2'd1, WEN_CZ = 2'd2, WEN_MASK = 2'd3;
  localparam logic [2:0] WA_IR119 = 3'd0, WA_IR53 = 3'd1, WA_CNT = 3'd2, WA_R7 = 3'd3, WA_IR86 = 3'd4;
  localparam logic [1:0] RD_IR86 = 2'd0, RD_CNT = 2'd1, RD_R7 = 2'd2;
  localparam logic DIN_MEM = 1'b0, DIN_T1 = 1'b1;
  localparam logic [1:0] MW_OFF = 2'd0, MW_ON = 2'd1, MW_MASK = 2'd2;
  localparam logic MD_A = 1'b0, MD_B = 1'b1;
  typedef struct packed {
    logic [2:0] alu_b;
    logic [2:0] alu_a;
    logic [1:0] rf_wen;
    logic [2:0] rf_wadd;
    logic [1:0] rf_read2;
    logic rf_din;
    logic [1:0] mem_wr;
    logic mem_din;
    logic cz_en;
    logic alu_op;
    logic w_ir;
    logic w_atmp;
    logic t1_write;
    logic [CNT_W-1:0] cnt;
  } ctrl_t;
  function automatic logic is_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_ADI, OP_NDU, OP_LHI};
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op inside {OP_LW, OP_SW};
  endfunction
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational control word from state, opcode and LM/SM counter
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t           i_state,
  input  logic [3:0]       i_op,
  input  logic [CNT_W-1:0] i_cnt,
  output ctrl_t            o_ctrl
);
  logic w_lm;
  assign w_lm = (i_op == OP_LM);
  always_comb begin
    o_ctrl = '0;
    o_ctrl.cnt = i_cnt;
    case (i_state)
      S_IF0, S_J0: begin
        o_ctrl.rf_read2 = RD_R7;
        o_ctrl.alu_b = B_RB;
        o_ctrl.t1_write = 1'b1;
      end
      S_IF1: o_ctrl.w_ir = 1'b1;
      S_IF2: begin
        o_ctrl.rf_read2 = RD_R7;
        o_ctrl.alu_a = A_ONE;
        o_ctrl.alu_b = B_RB;
        o_ctrl.t1_write = 1'b1;
      end
      S_IF3: begin
        o_ctrl.rf_din = DIN_T1;
        o_ctrl.rf_wadd = WA_R7;
        o_ctrl.rf_wen = WEN_ON;
      end
      S_EX: begin
        o_ctrl.alu_a = (i_op == OP_LHI) ? A_SHL7 : is_mem(i_op) ? A_IMM6 : A_RA;
        o_ctrl.alu_b = (i_op == OP_ADI) ? B_IMM6 : (i_op == OP_LHI) ? B_ZERO : B_RB;
        o_ctrl.cz_en = i_op inside {OP_ADD, OP_NDU, OP_ADI};
        o_ctrl.alu_op = (i_op == OP_NDU);
        o_ctrl.t1_write = 1'b1;
      end
      S_WB: begin
        o_ctrl.rf_din = DIN_T1;
        o_ctrl.rf_wen = (i_op inside {OP_ADD, OP_NDU}) ? WEN_CZ : WEN_ON;
        o_ctrl.rf_wadd = (i_op inside {OP_ADD, OP_NDU}) ? WA_IR53 : (i_op == OP_ADI) ? WA_IR86 : WA_IR119;
      end
      S_MEM: begin
        o_ctrl.rf_wen = (i_op == OP_LW) ? WEN_ON : WEN_OFF;
        o_ctrl.mem_wr = (i_op == OP_SW) ? MW_ON : MW_OFF;
      end
      S_BR0: begin
        o_ctrl.alu_a = A_RA;
        o_ctrl.alu_b = B_RB;
      end
      S_BR1, S_J2: begin
        o_ctrl.rf_read2 = RD_R7;
        o_ctrl.alu_a = (i_state == S_BR1) ? A_IMM6 : A_IMM9;
        o_ctrl.alu_b = B_RB;
        o_ctrl.t1_write = 1'b1;
      end
      S_J1: begin
        o_ctrl.rf_din = DIN_T1;
        o_ctrl.rf_wen = WEN_ON;
      end
      S_J3: begin
        o_ctrl.alu_b = B_RB;
        o_ctrl.t1_write = 1'b1;
      end
      S_MA: o_ctrl.w_atmp = 1'b1;
      S_MX: begin
        o_ctrl.alu_a = A_TMPA;
        o_ctrl.alu_b = B_CNT;
        o_ctrl.t1_write = 1'b1;
      end
      S_MW: begin
        o_ctrl.rf_wadd = w_lm ? WA_CNT : WA_IR119;
        o_ctrl.rf_wen = w_lm ? WEN_MASK : WEN_OFF;
        o_ctrl.rf_read2 = w_lm ? RD_IR86 : RD_CNT;
        o_ctrl.mem_din = w_lm ? MD_A : MD_B;
        o_ctrl.mem_wr = w_lm ? MW_OFF : MW_MASK;
      end
      default: o_ctrl.cnt = i_cnt;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM sequencing fetch, execute, memory and writeback for IITB-RISC
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             proc_rst,
  input  logic [15:0]      IRout,
  input  logic             compare,
  output logic [2:0]       Mux1_alu_B,
  output logic [2:0]       Mux2_alu_A,
  output logic [1:0]       Mux3_RF_wen,
  output logic [2:0]       Mux4_RF_wadd,
  output logic [1:0]       Mux5_RF_read2,
  output logic             Mux6_RF_dataIn,
  output logic [1:0]       Mux8_memwrite,
  output logic             Mux9_memDataIn,
  output logic             CZ_en,
  output logic             ALU_op,
  output logic             wIR,
  output logic             wAtmp,
  output logic             T1write,
  output logic [CNT_W-1:0] counter,
  output logic [ST_W-1:0]  fsm_state
);
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_redir;
  logic [3:0] w_op;
  logic w_unused;
  ctrl_t w_ctrl, w_out;
  assign w_op = IRout[15:12];
  assign w_unused = ^IRout[11:0];
  mc_ctrl_decode u_dec (.i_state(r_state), .i_op(w_op), .i_cnt(r_cnt), .o_ctrl(w_ctrl));
  // IF3 entered after a branch/jump only commits the new PC, then refetches
  always_comb begin
    w_state_nxt = S_IF0;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IF0: w_state_nxt = S_IF1;
      S_IF1: w_state_nxt = S_IF2;
      S_IF2: w_state_nxt = S_IF3;
      S_IF3: w_state_nxt = r_redir ? S_IF0
                         : (is_alu(w_op) || is_mem(w_op)) ? S_EX
                         : (w_op == OP_BEQ) ? S_BR0
                         : (w_op inside {OP_JAL, OP_JLR}) ? S_J0
                         : (w_op inside {OP_LM, OP_SM}) ? S_MA : S_IF0;
      S_EX: w_state_nxt = is_mem(w_op) ? S_MEM : S_WB;
      S_BR0: w_state_nxt = compare ? S_BR1 : S_IF0;
      S_BR1, S_J2, S_J3: w_state_nxt = S_IF3;
      S_J0: w_state_nxt = S_J1;
      S_J1: w_state_nxt = (w_op == OP_JAL) ? S_J2 : S_J3;
      S_MA: begin
        w_state_nxt = S_MX;
        w_cnt_nxt = '0;
      end
      S_MX: w_state_nxt = S_MW;
      S_MW: begin
        w_state_nxt = (&r_cnt) ? S_IF0 : S_MX;
        w_cnt_nxt = (&r_cnt) ? '0 : r_cnt + CNT_W'(1);
      end
      default: w_state_nxt = S_IF0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (proc_rst) begin
      r_state <= S_IF0;
      r_cnt <= '0;
      r_redir <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_redir <= r_state inside {S_BR1, S_J2, S_J3};
    end
  end
  assign w_out = proc_rst ? '0 : w_ctrl;
  assign Mux1_alu_B = w_out.alu_b;
  assign Mux2_alu_A = w_out.alu_a;
  assign Mux3_RF_wen = w_out.rf_wen;
  assign Mux4_RF_wadd = w_out.rf_wadd;
  assign Mux5_RF_read2 = w_out.rf_read2;
  assign Mux6_RF_dataIn = w_out.rf_din;
  assign Mux8_memwrite = w_out.mem_wr;
  assign Mux9_memDataIn = w_out.mem_din;
  assign CZ_en = w_out.cz_en;
  assign ALU_op = w_out.alu_op;
  assign wIR = w_out.w_ir;
  assign wAtmp = w_out.w_atmp;
  assign T1write = w_out.t1_write;
  assign counter = w_out.cnt;
  assign fsm_state = proc_rst ? '0 : r_state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction streams checked cycle by cycle against a per-opcode reference model
module tb_mc_controller;
  import mc_ctrl_pkg::*;
  logic clk = 1'b0, proc_rst = 1'b1, compare = 1'b0;
  logic [15:0] IRout = '0;
  logic [2:0] Mux1_alu_B, Mux2_alu_A, Mux4_RF_wadd, counter;
  logic [1:0] Mux3_RF_wen, Mux5_RF_read2, Mux8_memwrite;
  logic Mux6_RF_dataIn, Mux9_memDataIn, CZ_en, ALU_op, wIR, wAtmp, T1write;
  logic [4:0] fsm_state;
  logic [24:0] obs;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    state_t st;
    logic [2:0] c;
  } step_t;
  step_t exp_q[$];

  mc_controller dut (
    .clk(clk), .proc_rst(proc_rst), .IRout(IRout), .compare(compare),
    .Mux1_alu_B(Mux1_alu_B), .Mux2_alu_A(Mux2_alu_A), .Mux3_RF_wen(Mux3_RF_wen),
    .Mux4_RF_wadd(Mux4_RF_wadd), .Mux5_RF_read2(Mux5_RF_read2), .Mux6_RF_dataIn(Mux6_RF_dataIn),
    .Mux8_memwrite(Mux8_memwrite), .Mux9_memDataIn(Mux9_memDataIn), .CZ_en(CZ_en), .ALU_op(ALU_op),
    .wIR(wIR), .wAtmp(wAtmp), .T1write(T1write), .counter(counter), .fsm_state(fsm_state)
  );

  assign obs = {Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2, Mux6_RF_dataIn,
                Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op, wIR, wAtmp, T1write, counter};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // expected control word straight from the per-state control table, numeric selects as listed on the ports
  function automatic logic [24:0] exp_ctrl(input state_t st, input logic [3:0] op, input logic [2:0] c);
    logic [2:0] b, a, wadd;
    logic [1:0] wen, rd2, mw;
    logic din, mdi, cz, alu, wir, wat, t1;
    {b, a, wadd, wen, rd2, mw, din, mdi, cz, alu, wir, wat, t1} = '0;
    case (st)
      S_IF0, S_J0: begin rd2 = 2; b = 2; t1 = 1; end
      S_IF1: wir = 1;
      S_IF2: begin rd2 = 2; a = 1; b = 2; t1 = 1; end
      S_IF3: begin din = 1; wadd = 3; wen = 1; end
      S_EX: begin
        t1 = 1;
        if (op == 0 || op == 2) begin a = 5; b = 2; alu = op[1]; cz = 1; end
        else if (op == 1) begin a = 5; b = 3; cz = 1; end
        else if (op == 3) begin a = 2; b = 0; end
        else begin a = 3; rd2 = 0; b = 2; end
      end
      S_WB: begin
        din = 1;
        if (op == 1) begin wadd = 4; wen = 1; end
        else if (op == 3) begin wadd = 0; wen = 1; end
        else begin wadd = 1; wen = 2; end
      end
      S_MEM: if (op == 4) begin din = 0; wadd = 0; wen = 1; end else begin mdi = 0; mw = 1; end
      S_BR0: begin a = 5; b = 2; end
      S_BR1: begin rd2 = 2; a = 3; b = 2; t1 = 1; end
      S_J1: begin din = 1; wadd = 0; wen = 1; end
      S_J2: begin rd2 = 2; a = 4; b = 2; t1 = 1; end
      S_J3: begin rd2 = 0; a = 0; b = 2; t1 = 1; end
      S_MA: wat = 1;
      S_MX: begin a = 6; b = 4; t1 = 1; end
      S_MW: if (op == 6) begin din = 0; wadd = 2; wen = 3; end else begin rd2 = 1; mdi = 1; mw = 2; end
      default: ;
    endcase
    return {b, a, wen, wadd, rd2, din, mw, mdi, cz, alu, wir, wat, t1, c};
  endfunction

  function automatic void push(input state_t s, input int c);
    exp_q.push_back('{s, 3'(c)});
  endfunction

  // the cycle-by-cycle state trace each instruction class must follow
  function automatic void build(input logic [15:0] ir, input logic cmp);
    logic [3:0] op;
    op = ir[15:12];
    exp_q.delete();
    push(S_IF0, 0); push(S_IF1, 0); push(S_IF2, 0); push(S_IF3, 0);
    if (op <= 3) begin push(S_EX, 0); push(S_WB, 0); end
    else if (op == 4 || op == 5) begin push(S_EX, 0); push(S_MEM, 0); end
    else if (op == 4'hC) begin
      push(S_BR0, 0);
      if (cmp) begin push(S_BR1, 0); push(S_IF3, 0); end
    end else if (op == 8 || op == 9) begin
      push(S_J0, 0); push(S_J1, 0); push(op == 8 ? S_J2 : S_J3, 0); push(S_IF3, 0);
    end else if (op == 6 || op == 7) begin
      push(S_MA, 0);
      for (int c = 0; c < 8; c++) begin push(S_MX, c); push(S_MW, c); end
    end
  endfunction

  task automatic test_exec(input string name, input logic [15:0] ir, input logic cmp);
    logic [24:0] want;
    build(ir, cmp);
    IRout = ir;
    compare = cmp;
    foreach (exp_q[i]) begin
      #1;
      want = exp_ctrl(exp_q[i].st, ir[15:12], exp_q[i].c);
      n_cmp++;
      if (fsm_state !== exp_q[i].st || obs !== want) begin
        n_err++;
        $display("FAIL %s ir=%h step %0d: state %0d ctrl %h, expected state %0d ctrl %h",
                 name, ir, i, fsm_state, obs, exp_q[i].st, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    proc_rst = 1;
    IRout = 16'h6055;
    compare = 1;
    repeat (2) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (obs !== '0 || fsm_state !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: state %0d ctrl %h, expected 0 and 0", fsm_state, obs);
      end
    end
    proc_rst = 0;
    #1;
    n_cmp++;
    if (fsm_state !== S_IF0 || obs !== exp_ctrl(S_IF0, 4'h6, 3'd0)) begin
      n_err++;
      $display("FAIL reset_release: state %0d ctrl %h, expected state %0d ctrl %h",
               fsm_state, obs, S_IF0, exp_ctrl(S_IF0, 4'h6, 3'd0));
    end
  endtask

  task automatic test_sm_reset();
    bit hit = 0;
    IRout = 16'h70F3;
    compare = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      #1;
      if (fsm_state == S_MX && counter == 3) hit = 1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL sm_reach_cnt3: counter 3 not seen within 40 cycles, state %0d", fsm_state);
    end
    proc_rst = 1;
    #1;
    n_cmp++;
    if (obs !== '0 || fsm_state !== '0) begin
      n_err++;
      $display("FAIL sm_reset_outputs: state %0d ctrl %h, expected 0 and 0", fsm_state, obs);
    end
    @(negedge clk);
    proc_rst = 0;
    #1;
    n_cmp++;
    if (fsm_state !== S_IF0 || counter !== 3'd0 || Mux8_memwrite !== 2'd0) begin
      n_err++;
      $display("FAIL sm_reset_release: state %0d counter %0d memwrite %0d, expected %0d 0 0",
               fsm_state, counter, Mux8_memwrite, S_IF0);
    end
  endtask

  task automatic test_random(input int n);
    logic [15:0] ir;
    for (int i = 0; i < n; i++) begin
      ir = 16'($urandom);
      test_exec("random", ir, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_exec("add", 16'h0298, 0);
    test_exec("beq_not_taken", 16'hC283, 0);
    test_exec("beq_taken", 16'hC283, 1);
    test_exec("lm", 16'h6055, 0);
    test_exec("sm", 16'h7F01, 1);
    test_exec("jal", 16'h8405, 0);
    test_exec("jlr", 16'h9280, 1);
    test_exec("lw", 16'h4A41, 0);
    test_exec("sw", 16'h5A41, 0);
    test_exec("lhi", 16'h3FFF, 0);
    test_exec("illegal", 16'hE123, 1);
    test_sm_reset();
    test_exec("lm_after_reset", 16'h60FF, 0);
    test_random(60);
    test_reset();
    test_exec("add_after_reset", 16'h2298, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
